cmult_seq: RTL and testbench

//  Sequential complex multiplier: (re_a + j*im_a) * (re_q + j*im_q) -> re_res + j*im_res.

---
 rtl/cmult_pkg.sv | 47 ++++
 rtl/cmult_mul_unit.sv | 13 +
 rtl/cmult_seq.sv | 160 ++++++++++++++++
 tb/tb_cmult_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// Shared types and helpers for the sequential complex multiplier.
// Optional feature macro: CMULT_SAT_EN (saturating reduction instead of wrap-around).
package cmult_pkg;

    // Word width of operands and results; cmult_seq's WIDTH must match this value.
    localparam int WORD_W = 8;
    // Accumulator width: one bit above a full product so a sum or difference of two products fits.
    localparam int ACC_W  = 2 * WORD_W + 1;

    // Representable range of a result word, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WORD_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (WORD_W - 1));

    typedef enum logic [2:0] {
        IDLE,
        MUL_RR,
        MUL_II,
        MUL_RI,
        MUL_IR,
        DONE
    } cmult_state_t;

    // Reduce a full-precision accumulator to one result word.
    function automatic logic [WORD_W-1:0] reduce_word(input logic signed [ACC_W-1:0] acc);
        logic [WORD_W-1:0] word;
`ifdef CMULT_SAT_EN
        if (acc > SAT_MAX) begin
            word = SAT_MAX[WORD_W-1:0];
        end else if (acc < SAT_MIN) begin
            word = SAT_MIN[WORD_W-1:0];
        end else begin
            word = acc[WORD_W-1:0];
        end
`else
        word = acc[WORD_W-1:0];
`endif
        return word;
    endfunction

`ifdef CMULT_SAT_EN
    // High when reduce_word would clip this accumulator value.
    function automatic logic word_clips(input logic signed [ACC_W-1:0] acc);
        return (acc > SAT_MAX) || (acc < SAT_MIN);
    endfunction
`endif

endpackage

// File: rtl/cmult_mul_unit.sv
// Combinational signed WIDTH x WIDTH -> 2*WIDTH multiplier, shared by all product steps.
module cmult_mul_unit #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    // Both operands signed, so the product is a full-precision signed result.
    assign p = a * b;

endmodule

// File: rtl/cmult_seq.sv
// Sequential complex multiplier: one shared multiplier stepped over four states.
// Optional feature macro: CMULT_SAT_EN adds saturating reduction and the `sat` output.
module cmult_seq
    import cmult_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] re_a,
    input  logic [WIDTH-1:0] im_a,
    input  logic [WIDTH-1:0] re_q,
    input  logic [WIDTH-1:0] im_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] re_res,
    output logic [WIDTH-1:0] im_res
`ifdef CMULT_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int AW = 2 * WIDTH + 1;

    cmult_state_t state_q, state_d;

    logic signed [WIDTH-1:0] re_a_q, re_a_d, im_a_q, im_a_d;
    logic signed [WIDTH-1:0] re_q_q, re_q_d, im_q_q, im_q_d;
    logic signed [AW-1:0]    re_acc_q, re_acc_d, im_acc_q, im_acc_d;
    logic [WIDTH-1:0]        re_res_q, re_res_d, im_res_q, im_res_d;
`ifdef CMULT_SAT_EN
    logic                    sat_q, sat_d;
`endif

    logic signed [WIDTH-1:0]   mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      prod_ext;

    cmult_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    assign prod_ext = {prod[2*WIDTH-1], prod};

    // Operand mux: the current product step selects which latched operand pair feeds the multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_RR:  begin mul_a = re_a_q; mul_b = re_q_q; end
            MUL_II:  begin mul_a = im_a_q; mul_b = im_q_q; end
            MUL_RI:  begin mul_a = re_a_q; mul_b = im_q_q; end
            MUL_IR:  begin mul_a = im_a_q; mul_b = re_q_q; end
            default: begin mul_a = '0;     mul_b = '0;     end
        endcase
    end

    // Next-state, operand capture, accumulation and result load.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        re_a_d   = re_a_q;
        im_a_d   = im_a_q;
        re_q_d   = re_q_q;
        im_q_d   = im_q_q;
        re_acc_d = re_acc_q;
        im_acc_d = im_acc_q;
        re_res_d = re_res_q;
        im_res_d = im_res_q;
`ifdef CMULT_SAT_EN
        sat_d    = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    re_a_d   = re_a;
                    im_a_d   = im_a;
                    re_q_d   = re_q;
                    im_q_d   = im_q;
                    re_acc_d = '0;
                    im_acc_d = '0;
                    state_d  = MUL_RR;
                end else begin
                    state_d  = IDLE;
                end
            end
            MUL_RR: begin
                re_acc_d = re_acc_q + prod_ext;
                state_d  = MUL_II;
            end
            MUL_II: begin
                re_acc_d = re_acc_q - prod_ext;
                state_d  = MUL_RI;
            end
            MUL_RI: begin
                im_acc_d = im_acc_q + prod_ext;
                state_d  = MUL_IR;
            end
            MUL_IR: begin
                im_acc_d = im_acc_q + prod_ext;
                re_res_d = reduce_word(re_acc_q);
                im_res_d = reduce_word(im_acc_d);
`ifdef CMULT_SAT_EN
                sat_d    = word_clips(re_acc_q) || word_clips(im_acc_d);
`endif
                state_d  = DONE;
            end
            default: begin
                state_d  = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so a mid-operation reset drops the partial result.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every register here is a small flop, so all of them take the async reset.
        if (!reset_n) begin
            state_q  <= IDLE;
            re_a_q   <= '0;
            im_a_q   <= '0;
            re_q_q   <= '0;
            im_q_q   <= '0;
            re_acc_q <= '0;
            im_acc_q <= '0;
            re_res_q <= '0;
            im_res_q <= '0;
`ifdef CMULT_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its inputs.
            state_q  <= state_d;
            re_a_q   <= re_a_d;
            im_a_q   <= im_a_d;
            re_q_q   <= re_q_d;
            im_q_q   <= im_q_d;
            re_acc_q <= re_acc_d;
            im_acc_q <= im_acc_d;
            re_res_q <= re_res_d;
            im_res_q <= im_res_d;
`ifdef CMULT_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign busy   = (state_q == MUL_RR) || (state_q == MUL_II) ||
                    (state_q == MUL_RI) || (state_q == MUL_IR);
    assign done   = (state_q == DONE);
    assign re_res = re_res_q;
    assign im_res = im_res_q;
`ifdef CMULT_SAT_EN
    assign sat    = sat_q;
`endif

endmodule

// File: tb/tb_cmult_seq.sv
// Directed bench for cmult_seq (WIDTH=8); expectations are hand-computed complex products.
module tb_cmult_seq;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] re_a = '0, im_a = '0, re_q = '0, im_q = '0;
    logic       busy, done;
    logic [7:0] re_res, im_res;
`ifdef CMULT_SAT_EN
    logic       sat;
`endif

    int total = 0;
    int bad   = 0;
    int cyc;
    int bcnt;
    int dcnt;

    always #5 clk = ~clk;

    cmult_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .re_a    (re_a),
        .im_a    (im_a),
        .re_q    (re_q),
        .im_q    (im_q),
        .busy    (busy),
        .done    (done),
        .re_res  (re_res),
        .im_res  (im_res)
`ifdef CMULT_SAT_EN
        ,
        .sat     (sat)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] ra, input logic [7:0] ia,
                           input logic [7:0] rq, input logic [7:0] iq);
        re_a = ra;
        im_a = ia;
        re_q = rq;
        im_q = iq;
    endtask

    // Called right after a negedge with start driven; returns the negedge index at which done was
    // seen (0 on timeout) and how many of the preceding negedges showed busy.
    task automatic wait_done(input bit hold, output int n, output int busy_seen);
        n = 0;
        busy_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                break;
            end
            if (busy === 1'b1) busy_seen++;
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst busy", 8'(busy), 8'h00);
        chk("rst done", 8'(done), 8'h00);
        chk("rst re", re_res, 8'h00);
        chk("rst im", im_res, 8'h00);
`ifdef CMULT_SAT_EN
        chk("rst sat", 8'(sat), 8'h00);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // 1: (1+2j)(3+4j) = -5+10j
        @(negedge clk);
        set_ops(8'h01, 8'h02, 8'h03, 8'h04);
        start = 1'b1;
        wait_done(1'b0, cyc, bcnt);
        chk("t1 latency", 8'(cyc), 8'd5);
        chk("t1 busy cycles", 8'(bcnt), 8'd4);
        chk("t1 re", re_res, 8'hFB);
        chk("t1 im", im_res, 8'h0A);
`ifdef CMULT_SAT_EN
        chk("t1 sat", 8'(sat), 8'h00);
`endif
        @(negedge clk);
        chk("t1 done pulse", 8'(done), 8'h00);
        chk("t1 re hold", re_res, 8'hFB);

        // 2: (100)(2) = 200 -> wraps to -56 or saturates to 127
        set_ops(8'h64, 8'h00, 8'h02, 8'h00);
        start = 1'b1;
        wait_done(1'b0, cyc, bcnt);
        chk("t2 latency", 8'(cyc), 8'd5);
`ifdef CMULT_SAT_EN
        chk("t2 re", re_res, 8'h7F);
        chk("t2 sat", 8'(sat), 8'h01);
`else
        chk("t2 re", re_res, 8'hC8);
`endif
        chk("t2 im", im_res, 8'h00);
        @(negedge clk);
`ifdef CMULT_SAT_EN
        chk("t2 sat clear", 8'(sat), 8'h00);
`endif

        // 3: (-128)(-128) = 16384 -> wraps to 0 or saturates to 127
        set_ops(8'h80, 8'h00, 8'h80, 8'h00);
        start = 1'b1;
        wait_done(1'b0, cyc, bcnt);
        chk("t3 latency", 8'(cyc), 8'd5);
`ifdef CMULT_SAT_EN
        chk("t3 re", re_res, 8'h7F);
        chk("t3 sat", 8'(sat), 8'h01);
`else
        chk("t3 re", re_res, 8'h00);
`endif
        chk("t3 im", im_res, 8'h00);
        @(negedge clk);

        // 4: operands and start change during MUL_II are ignored
        set_ops(8'h01, 8'h02, 8'h03, 8'h04);
        start = 1'b1;
        @(negedge clk);                 // MUL_RR
        start = 1'b0;
        @(negedge clk);                 // MUL_II
        set_ops(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        start = 1'b1;
        @(negedge clk);                 // MUL_RI
        start = 1'b0;
        @(negedge clk);                 // MUL_IR
        chk("t4 busy", 8'(busy), 8'h01);
        @(negedge clk);                 // DONE
        chk("t4 done", 8'(done), 8'h01);
        chk("t4 re", re_res, 8'hFB);
        chk("t4 im", im_res, 8'h0A);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("t4 no second done", 8'(dcnt), 8'd0);

        // 5: start held high, back-to-back: -5+10j then (-3-j)(2+5j) = -1-17j
        set_ops(8'h01, 8'h02, 8'h03, 8'h04);
        start = 1'b1;
        wait_done(1'b1, cyc, bcnt);
        chk("t5a latency", 8'(cyc), 8'd5);
        chk("t5a re", re_res, 8'hFB);
        chk("t5a im", im_res, 8'h0A);
        set_ops(8'hFD, 8'hFF, 8'h02, 8'h05);
        wait_done(1'b0, cyc, bcnt);
        chk("t5b period", 8'(cyc), 8'd5);
        chk("t5b busy cycles", 8'(bcnt), 8'd4);
        chk("t5b re", re_res, 8'hFF);
        chk("t5b im", im_res, 8'hEF);
        @(negedge clk);
        chk("t5 idle busy", 8'(busy), 8'h00);
        chk("t5 idle done", 8'(done), 8'h00);

        // 6: reset during MUL_RI clears outputs at once and suppresses done
        set_ops(8'h01, 8'h02, 8'h03, 8'h04);
        start = 1'b1;
        @(negedge clk);                 // MUL_RR
        start = 1'b0;
        @(negedge clk);                 // MUL_II
        @(negedge clk);                 // MUL_RI
        chk("t6 pre-reset busy", 8'(busy), 8'h01);
        #1 reset_n = 1'b0;
        #1;
        chk("t6 busy", 8'(busy), 8'h00);
        chk("t6 done", 8'(done), 8'h00);
        chk("t6 re", re_res, 8'h00);
        chk("t6 im", im_res, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("t6 no done", 8'(dcnt), 8'd0);
        set_ops(8'hFD, 8'hFF, 8'h02, 8'h05);
        start = 1'b1;
        wait_done(1'b0, cyc, bcnt);
        chk("t6 next latency", 8'(cyc), 8'd5);
        chk("t6 next re", re_res, 8'hFF);
        chk("t6 next im", im_res, 8'hEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
